goldschmidt_int_div: RTL and testbench
======================================

Name: goldschmidt_int_div

Overview:
Integer front/back-end for the goldschmidt fractional divider.
- Accepts unsigned 32-bit dividend/divisor and normalizes both to the divider's fraction format.
- Handles the trivial cases (divisor zero, dividend zero, dividend < divisor by exponent) without the divider.
- Drives the divider's start, then captures its quotient fraction.
- Denormalizes the fraction and corrects it to an exact integer quotient and remainder.
- Sits directly upstream of the divider (feeds a, b, start) and downstream of it (consumes q, ready).

Parameters:
WIDTH, 32, operand/result width; divider interface is fixed at 32 bits.
MAX_FIX, 2, maximum quotient correction steps (±1 each) after scaling.

Ports:
clk  in  1  clock, rising edge
clrn  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
dividend  in  32  unsigned N
divisor  in  32  unsigned D
quotient  out  32  floor(N/D)
remainder  out  32  N - quotient*D
dbz  out  1  divide-by-zero flag for the last result
busy  out  1  operation in progress
ready  out  1  one-cycle result-valid pulse
div_a  out  32  to divider: normalized dividend, 0.1xxx (Q0.32, MSB=1)
div_b  out  32  to divider: normalized divisor, 0.1xxx (Q0.32, MSB=1)
div_start  out  1  to divider: one-cycle start pulse
div_q  in  32  from divider: quotient fraction, x.xxx (Q1.31)
div_ready  in  1  from divider: one-cycle pulse; div_q valid that cycle

Behaviour:
Reset (clrn=0, any time, including mid-operation):
- State goes to IDLE.
- quotient, remainder, div_a, div_b = 0; dbz, busy, ready, div_start = 0.
- A div_ready arriving after reset is ignored.

States: IDLE, NORM, ISSUE, WAIT, SCALE, FIX, DONE.
- IDLE: start=1 registers N and D and moves to NORM. busy=0.
- NORM:
  - la = lzc(N), lb = lzc(D); A = N<<la, B = D<<lb.
  - If D==0: quotient=0xFFFFFFFF, remainder=N, dbz=1, go to DONE.
  - Else if N==0, or la>lb: quotient=0, remainder=N, dbz=0, go to DONE. (la>lb guarantees N<D.)
  - Else: div_a=A, div_b=B, sh = 31-(lb-la) (range 0..31), go to ISSUE.
- ISSUE: div_start=1 for exactly this cycle; go to WAIT.
- WAIT: hold div_a and div_b stable; on div_ready=1 go to SCALE; otherwise stay (no timeout).
- SCALE: Qe = div_q >> sh (logical); fix count = 0; go to FIX.
- FIX: P = Qe*D as a 64-bit product.
  - If P > N: Qe = Qe-1.
  - Else if N-P >= D: Qe = Qe+1.
  - Else: quotient=Qe, remainder=N-P (low 32 bits), go to DONE.
  - Each adjustment increments the fix count. When the count reaches MAX_FIX, the next FIX cycle latches its result and goes to DONE regardless; the bench flags this as a failure.
- DONE: ready=1 for one cycle; go to IDLE.

Output and timing rules:
- busy=1 in NORM, ISSUE, WAIT, SCALE, FIX; busy=0 in IDLE and DONE.
- start is ignored unless in IDLE. start held high re-triggers on the cycle after DONE.
- quotient, remainder and dbz hold from DONE until the next NORM updates them.
- Latency from the start edge to ready high:
  - Bypass path: 2 cycles.
  - Divider path: 5 cycles + divider latency (ISSUE to div_ready) + number of fix steps.
- Arithmetic: all unsigned. Qe±1 never wraps for a divider with error of at most 2 ulp at the scaled position.

Test Plan:
- N=221, D=5 through a divider model (fixed 4-cycle latency, exact q) -> quotient=44, remainder=1, dbz=0; one div_start pulse; ready exactly one cycle.
- N=8, D=10 (la=lb=28, sh=31) -> divider used; quotient=0, remainder=8.
- N=3, D=100 (la>lb) and N=0, D=7 -> no div_start; quotient=0, remainder=3 and 0 respectively; ready 2 cycles after start.
- N=100, D=0 -> dbz=1, quotient=0xFFFFFFFF, remainder=100, no div_start.
- N=0xFFFFFFFF, D=1 with the model returning q one ulp low (0xFFFFFFFE fraction) -> one FIX increment; quotient=0xFFFFFFFF, remainder=0. Same N with D=3 and q one ulp high -> one decrement; quotient=0x55555555, remainder=0.
- clrn pulsed low during WAIT -> all outputs 0 immediately; the late div_ready is ignored. Next start with 221/5 -> correct result.

Source files
------------

// File: rtl/goldschmidt_int_div.sv
`default_nettype none
// ============================================================================
// Module   : goldschmidt_int_div
// Purpose  : Integer wrapper around a Goldschmidt fraction divider: normalizes
//            N/D, drives the divider, then rescales and corrects its quotient.
// Revision : 1.0 - initial release
// ============================================================================
module goldschmidt_int_div #(
    parameter int WIDTH   = 32,
    parameter int MAX_FIX = 2
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic             busy,
    output logic             ready,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    output logic             div_start,
    input  logic [31:0]      div_q,
    input  logic             div_ready
);

    localparam int CNT_W = $clog2(MAX_FIX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NORM  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_SCALE = 3'd4,
        S_FIX   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   n_q, n_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;
    logic [31:0]        div_a_q, div_a_d;
    logic [31:0]        div_b_q, div_b_d;
    logic [4:0]         sh_q, sh_d;
    logic [31:0]        qraw_q, qraw_d;
    logic [WIDTH-1:0]   qe_q, qe_d;
    logic [CNT_W-1:0]   fix_cnt_q, fix_cnt_d;

    logic [5:0]         w_la;
    logic [5:0]         w_lb;
    logic [5:0]         w_sh;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_rem;
    logic               w_over;

    function automatic logic [5:0] lzc(input logic [WIDTH-1:0] x);
        logic [5:0] cnt;
        logic       hit;
        cnt = 6'(WIDTH);
        hit = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!hit && x[i]) begin
                cnt = 6'(WIDTH - 1 - i);
                hit = 1'b1;
            end
        end
        return cnt;
    endfunction

    assign w_la   = lzc(n_q);
    assign w_lb   = lzc(d_q);
    assign w_sh   = 6'd31 - (w_lb - w_la);
    assign w_prod = {{WIDTH{1'b0}}, qe_q} * {{WIDTH{1'b0}}, d_q};
    assign w_over = w_prod > {{WIDTH{1'b0}}, n_q};
    // Only meaningful when the product does not exceed N, so low bits are exact.
    assign w_rem  = n_q - w_prod[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        d_d         = d_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        sh_d        = sh_q;
        qraw_d      = qraw_q;
        qe_d        = qe_q;
        fix_cnt_d   = fix_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = dividend;
                    d_d     = divisor;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (d_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = n_q;
                    dbz_d       = 1'b1;
                    state_d     = S_DONE;
                end else if (n_q == '0 || w_la > w_lb) begin
                    // More leading zeros in N than in D means N < D.
                    quotient_d  = '0;
                    remainder_d = n_q;
                    dbz_d       = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    dbz_d   = 1'b0;
                    div_a_d = n_q << w_la;
                    div_b_d = d_q << w_lb;
                    sh_d    = w_sh[4:0];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // div_q is only valid in the div_ready cycle, so capture it here.
                if (div_ready) begin
                    qraw_d  = div_q;
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                qe_d      = qraw_q >> sh_q;
                fix_cnt_d = '0;
                state_d   = S_FIX;
            end
            S_FIX: begin
                if (fix_cnt_q == CNT_W'(MAX_FIX)) begin
                    quotient_d  = qe_q;
                    remainder_d = w_rem;
                    state_d     = S_DONE;
                end else if (w_over) begin
                    qe_d      = qe_q - 1'b1;
                    fix_cnt_d = fix_cnt_q + CNT_W'(1);
                end else if (w_rem >= d_q) begin
                    qe_d      = qe_q + 1'b1;
                    fix_cnt_d = fix_cnt_q + CNT_W'(1);
                end else begin
                    quotient_d  = qe_q;
                    remainder_d = w_rem;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            d_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            sh_q        <= '0;
            qraw_q      <= '0;
            qe_q        <= '0;
            fix_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            d_q         <= d_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            sh_q        <= sh_d;
            qraw_q      <= qraw_d;
            qe_q        <= qe_d;
            fix_cnt_q   <= fix_cnt_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign busy      = (state_q == S_NORM)  || (state_q == S_ISSUE) ||
                       (state_q == S_WAIT)  || (state_q == S_SCALE) ||
                       (state_q == S_FIX);
    assign ready     = (state_q == S_DONE);
    assign div_start = (state_q == S_ISSUE);

endmodule
`default_nettype wire

// File: tb/tb_goldschmidt_int_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_goldschmidt_int_div
// Purpose  : Scoreboard bench for goldschmidt_int_div with a fraction-divider model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_goldschmidt_int_div;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient, remainder, div_a, div_b;
    logic        dbz, busy, ready, div_start;
    logic [31:0] div_q = '0;
    logic        div_ready = 1'b0;

    goldschmidt_int_div #(.WIDTH(32), .MAX_FIX(2)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .busy      (busy),
        .ready     (ready),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_start (div_start),
        .div_q     (div_q),
        .div_ready (div_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    int     dstart_cnt = 0;
    longint div_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lz(input logic [31:0] x);
        for (int i = 31; i >= 0; i--)
            if (x[i]) return 31 - i;
        return 32;
    endfunction

    // Fraction divider model: exact floor(a/b * 2^31) plus an injected error.
    initial begin : divider_model
        logic [31:0] ma, mb;
        logic [63:0] qx;
        longint      tmp;
        forever begin
            @(negedge clk);
            if (div_start === 1'b1) begin
                dstart_cnt++;
                ma = div_a;
                mb = div_b;
                check("div_a_msb", 64'(ma[31]), 64'd1);
                check("div_b_msb", 64'(mb[31]), 64'd1);
                qx  = ({32'b0, ma} << 31) / {32'b0, mb};
                tmp = longint'(qx) + div_err;
                if (tmp < 0) tmp = 0;
                if (tmp > 64'hFFFF_FFFF) tmp = 64'hFFFF_FFFF;
                repeat (3) @(negedge clk);
                div_q     = tmp[31:0];
                div_ready = 1'b1;
                @(negedge clk);
                div_ready = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every ready pulse.
    initial begin : monitor
        logic prev_ready;
        exp_t e;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (ready === 1'b1) begin
                if (prev_ready) check("ready_single_cycle", 64'd1, 64'd0);
                if (sb.size() == 0) begin
                    check("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", 64'(quotient), 64'(e.q));
                    check("remainder", 64'(remainder), 64'(e.r));
                    check("dbz", 64'(dbz), 64'(e.dbz));
                end
            end
            prev_ready = (ready === 1'b1);
        end
    end

    task automatic run_op(input logic [31:0] n, input logic [31:0] d, input longint err);
        exp_t e;
        bit   bypass;
        bit   got;
        int   k;
        int   cnt0;
        bypass = (d == 0) || (n == 0) || (lz(n) > lz(d));
        if (d == 0) begin
            e.q = 32'hFFFF_FFFF; e.r = n; e.dbz = 1'b1;
        end else begin
            e.q = n / d; e.r = n % d; e.dbz = 1'b0;
        end
        sb.push_back(e);
        cnt0 = dstart_cnt;
        @(posedge clk); #1;
        dividend = n; divisor = d; div_err = err; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        k = 0; got = 0;
        while (k < 200 && !got) begin
            @(posedge clk); #1;
            k++;
            if (ready) got = 1;
        end
        if (!got) check("ready_timeout", 64'd0, 64'd1);
        else if (bypass) check("bypass_latency", 64'(k), 64'd1);
        @(negedge clk);
        check("div_start_pulses", 64'(dstart_cnt - cnt0), bypass ? 64'd0 : 64'd1);
    endtask

    // Divider error of e units at the scaled quotient position.
    function automatic longint scaled_err(input logic [31:0] n, input logic [31:0] d, input int e);
        int sh;
        if (d == 0 || n == 0 || lz(n) > lz(d)) return 0;
        sh = 31 - (lz(d) - lz(n));
        return longint'(e) * (longint'(1) << sh);
    endfunction

    initial begin : stimulus
        logic [31:0] rn, rd;
        int          e;
        #12;
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_div_a", 64'(div_a), 64'd0);
        check("rst_div_b", 64'(div_b), 64'd0);
        check("rst_flags", 64'({dbz, busy, ready, div_start}), 64'd0);
        @(posedge clk); #1;
        clrn = 1'b1;

        run_op(32'd221, 32'd5, 0);
        run_op(32'd8, 32'd10, 0);
        run_op(32'd3, 32'd100, 0);
        run_op(32'd0, 32'd7, 0);
        run_op(32'd100, 32'd0, 0);
        run_op(32'hFFFF_FFFF, 32'd1, -1);
        run_op(32'hFFFF_FFFF, 32'd3, 2);

        // Reset while the divider is outstanding; its late div_ready must be ignored.
        @(posedge clk); #1;
        dividend = 32'd221; divisor = 32'd5; div_err = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("wait_busy", 64'(busy), 64'd1);
        clrn = 1'b0;
        #1;
        check("midrst_quotient", 64'(quotient), 64'd0);
        check("midrst_div_a", 64'(div_a), 64'd0);
        check("midrst_div_b", 64'(div_b), 64'd0);
        check("midrst_flags", 64'({dbz, busy, ready, div_start}), 64'd0);
        @(posedge clk); #1;
        clrn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("late_ready_ignored", 64'({quotient, busy}), 64'd0);
        run_op(32'd221, 32'd5, 0);

        for (int i = 0; i < 40; i++) begin
            rn = $urandom;
            rd = $urandom >> $urandom_range(0, 31);
            if (i % 13 == 5) rd = 0;
            if (i % 11 == 3) rn = 0;
            if (i % 4 == 1) rn = rn >> $urandom_range(0, 31);
            e = int'($urandom_range(0, 2)) - 1;
            run_op(rn, rd, scaled_err(rn, rd, e));
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
